// File: rtl/alu_op_decoder.sv
// RV32I OP/OP-IMM decode stage with a 2-entry skid buffer (output reg + skid reg), 1-cycle latency.
// Optional illegal-instruction counter under ALU_OP_DECODER_ILLEGAL_CNT_EN; in_ready is registered.
package pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } t_alu_op;

  typedef struct packed {
    t_alu_op     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
  } t_dec;

endpackage

module alu_op_decoder #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output pkg::t_alu_op      out_alu_op,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [31:0]       out_imm,
  output logic              out_use_imm,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  import pkg::*;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  t_dec       dec;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_ADD;
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    legal       = 1'b0;

    case (opcode)
      OPC_OP: begin
        legal      = (f7 == F7_ZERO) ||
                     ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        dec.alu_op = t_alu_op'({f7[5], f3});
      end
      OPC_OP_IMM: begin
        dec.use_imm = 1'b1;
        dec.imm     = {{20{in_instr[31]}}, in_instr[31:20]};
        case (f3)
          3'b001: begin
            legal      = (f7 == F7_ZERO);
            dec.alu_op = ALU_SLL;
            dec.imm    = {27'd0, in_instr[24:20]};
          end
          3'b101: begin
            legal      = (f7 == F7_ZERO) || (f7 == F7_ALT);
            dec.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
            dec.imm    = {27'd0, in_instr[24:20]};
          end
          default: begin
            // f7 is part of the immediate here, so ADDI can never become SUB
            legal      = 1'b1;
            dec.alu_op = t_alu_op'({1'b0, f3});
          end
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec.alu_op  = ALU_ADD;
      dec.use_imm = 1'b0;
      dec.imm     = '0;
      dec.illegal = 1'b1;
    end
  end

  t_dec out_dat;
  t_dec skid_dat;
  logic skid_vld;
  logic accept;
  logic drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Accept is impossible while the skid holds an entry, since in_ready is then low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      skid_vld  <= 1'b0;
      in_ready  <= 1'b0;
      out_dat   <= '0;
      skid_dat  <= '0;
    end else begin
      if (!out_valid || out_ready) begin
        if (skid_vld) begin
          out_dat   <= skid_dat;
          out_valid <= 1'b1;
          skid_vld  <= 1'b0;
        end else begin
          out_valid <= accept;
          if (accept) begin
            out_dat <= dec;
          end
        end
        in_ready <= 1'b1;
      end else if (accept) begin
        skid_dat <= dec;
        skid_vld <= 1'b1;
        in_ready <= 1'b0;
      end
    end
  end

  assign out_alu_op  = out_dat.alu_op;
  assign out_rs1     = out_dat.rs1;
  assign out_rs2     = out_dat.rs2;
  assign out_rd      = out_dat.rd;
  assign out_imm     = out_dat.imm;
  assign out_use_imm = out_dat.use_imm;
  assign out_illegal = out_dat.illegal;

`ifdef ALU_OP_DECODER_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (drain && out_dat.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign illegal_cnt = cnt_q;
`else
  assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: decode vector table plus handshake/backpressure/reset sequences.
module tb_alu_op_decoder;

  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  pkg::t_alu_op      out_alu_op;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic [31:0]       out_imm;
  logic              out_use_imm;
  logic              out_illegal;
  logic [CNT_W-1:0]  illegal_cnt;

  alu_op_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        ill;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cnt_step(input logic ill);
`ifdef ALU_OP_DECODER_ILLEGAL_CNT_EN
    if (ill && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = v.instr;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
    chk($sformatf("v%0d alu_op", i), 32'(out_alu_op), 32'(v.op));
    chk($sformatf("v%0d rs1", i), 32'(out_rs1), 32'(v.rs1));
    chk($sformatf("v%0d rs2", i), 32'(out_rs2), 32'(v.rs2));
    chk($sformatf("v%0d rd", i), 32'(out_rd), 32'(v.rd));
    chk($sformatf("v%0d imm", i), out_imm, v.imm);
    chk($sformatf("v%0d use_imm", i), 32'(out_use_imm), 32'(v.use_imm));
    chk($sformatf("v%0d illegal", i), 32'(out_illegal), 32'(v.ill));
    @(posedge clk);
    cnt_step(v.ill);
    @(negedge clk);
    chk($sformatf("v%0d drained", i), 32'(out_valid), 32'd0);
    chk($sformatf("v%0d illegal_cnt", i), 32'(illegal_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] got_op [$];
    int         got_cyc [$];
    logic [3:0] exp_op [3];
    logic       acc;

    vecs[0]  = '{32'h002081B3, 4'h0, 5'd1, 5'd2,  5'd3, 32'h0,        1'b0, 1'b0}; // ADD
    vecs[1]  = '{32'h402081B3, 4'h8, 5'd1, 5'd2,  5'd3, 32'h0,        1'b0, 1'b0}; // SUB
    vecs[2]  = '{32'h40335293, 4'hD, 5'd6, 5'd3,  5'd5, 32'h3,        1'b1, 1'b0}; // SRAI
    vecs[3]  = '{32'hFFF00093, 4'h0, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0}; // ADDI -1
    vecs[4]  = '{32'h4020A1B3, 4'h0, 5'd1, 5'd2,  5'd3, 32'h0,        1'b0, 1'b1}; // bad OP f7
    vecs[5]  = '{32'h00511093, 4'h1, 5'd2, 5'd5,  5'd1, 32'h5,        1'b1, 1'b0}; // SLLI
    vecs[6]  = '{32'h40511093, 4'h0, 5'd2, 5'd5,  5'd1, 32'h0,        1'b0, 1'b1}; // SLLI bad f7
    vecs[7]  = '{32'h00515093, 4'h5, 5'd2, 5'd5,  5'd1, 32'h5,        1'b1, 1'b0}; // SRLI
    vecs[8]  = '{32'h7FF1F213, 4'h7, 5'd3, 5'd31, 5'd4, 32'h000007FF, 1'b1, 1'b0}; // ANDI
    vecs[9]  = '{32'h80003093, 4'h3, 5'd0, 5'd0,  5'd1, 32'hFFFFF800, 1'b1, 1'b0}; // SLTIU -2048
    vecs[10] = '{32'h0000A083, 4'h0, 5'd1, 5'd0,  5'd1, 32'h0,        1'b0, 1'b1}; // LW
    vecs[11] = '{32'h022081B3, 4'h0, 5'd1, 5'd2,  5'd3, 32'h0,        1'b0, 1'b1}; // MUL
    vecs[12] = '{32'h4020D1B3, 4'hD, 5'd1, 5'd2,  5'd3, 32'h0,        1'b0, 1'b0}; // SRA
    vecs[13] = '{32'h0020E1B3, 4'h6, 5'd1, 5'd2,  5'd3, 32'h0,        1'b0, 1'b0}; // OR

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post-rst in_ready", 32'(in_ready), 32'd1);
    chk("post-rst out_valid", 32'(out_valid), 32'd0);
    chk("post-rst alu_op", 32'(out_alu_op), 32'd0);
    chk("post-rst regs", 32'({out_rs1, out_rs2, out_rd}), 32'd0);
    chk("post-rst imm", out_imm, 32'd0);
    chk("post-rst flags", 32'({out_use_imm, out_illegal}), 32'd0);
    chk("post-rst illegal_cnt", 32'(illegal_cnt), 32'd0);

    for (int i = 0; i < NV; i++) apply_vec(i);

    // SUB then SRAI on consecutive cycles
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h402081B3;
    @(posedge clk);
    #1 in_instr = 32'h40335293;
    @(negedge clk);
    chk("b2b first valid", 32'(out_valid), 32'd1);
    chk("b2b first op", 32'(out_alu_op), 32'h8);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b second valid", 32'(out_valid), 32'd1);
    chk("b2b second op", 32'(out_alu_op), 32'hD);
    chk("b2b second imm", out_imm, 32'h3);
    chk("b2b second use_imm", 32'(out_use_imm), 32'd1);
    chk("b2b second rd", 32'(out_rd), 32'd5);
    chk("b2b second rs1", 32'(out_rs1), 32'd6);
    @(posedge clk);

    // Backpressure: three instructions with out_ready low
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3;
    @(posedge clk);
    #1 in_instr = 32'h402081B3;
    @(negedge clk);
    chk("bp one in_ready", 32'(in_ready), 32'd1);
    chk("bp one op", 32'(out_alu_op), 32'h0);
    @(posedge clk);
    #1 in_instr = 32'h0020E1B3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp full in_ready %0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp full valid %0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp full op %0d", k), 32'(out_alu_op), 32'h0);
      chk($sformatf("bp full rd %0d", k), 32'(out_rd), 32'd3);
      if (k < 2) @(posedge clk);
    end
    out_ready = 1'b1;
    exp_op[0] = 4'h0; exp_op[1] = 4'h8; exp_op[2] = 4'h6;
    for (int c = 0; c < 10 && got_op.size() < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid && out_ready) begin
        got_op.push_back(4'(out_alu_op));
        got_cyc.push_back(c);
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) #1 in_valid = 1'b0;
    end
    chk("bp drained count", 32'(got_op.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_op.size()) chk($sformatf("bp order %0d", k), 32'(got_op[k]), 32'(exp_op[k]));
    end
    if (got_cyc.size() == 3) chk("bp no bubble", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
    @(negedge clk);
    chk("bp empty after", 32'(out_valid), 32'd0);

    // Reset while FULL: held entries must vanish
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h4020A1B3;
    @(posedge clk);
    #1 in_instr = 32'h402081B3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rf full in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    exp_cnt = 0;
    @(negedge clk);
    chk("rf out_valid", 32'(out_valid), 32'd0);
    chk("rf in_ready", 32'(in_ready), 32'd0);
    chk("rf illegal_cnt", 32'(illegal_cnt), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rf in_ready after", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rf no ghost %0d", k), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    chk("rf illegal_cnt after", 32'(illegal_cnt), 32'(exp_cnt));

    // Illegal transfer after reset: counter 0 -> 1 when enabled
    apply_vec(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
